// File: rtl/stage2_tag_fifo_pkg.sv
// Shared definitions for the cipher pipeline stage blocks: tag lane modes and
// the per-lane reduction used to build tag bits.
package stage_pkg;

   localparam logic [1:0] MODE_XNOR = 2'b00;
   localparam logic [1:0] MODE_OR   = 2'b01;
   localparam logic [1:0] MODE_AND  = 2'b10;
   localparam logic [1:0] MODE_M3   = 2'b11;

   // Widest lane slice any stage block may hand to reduce_tag.
   localparam int SLICE_MAX = 64;

   // Bits of slice at or above slice_w are ignored, so AND-reduce of a narrow
   // lane is not spoiled by zero padding.
   function automatic logic reduce_tag(input logic [SLICE_MAX-1:0] slice,
                                       input logic [1:0]           mode,
                                       input logic                 legacy,
                                       input int                   slice_w);
      logic any_one;
      logic all_one;
      logic parity;
      any_one = 1'b0;
      all_one = 1'b1;
      parity  = 1'b0;
      for (int i = 0; i < SLICE_MAX; i++) begin
         if (i < slice_w) begin
            any_one = any_one | slice[i];
            all_one = all_one & slice[i];
            parity  = parity ^ slice[i];
         end
      end
      case (mode)
         MODE_XNOR: reduce_tag = ~parity;
         MODE_OR:   reduce_tag = any_one;
         MODE_AND:  reduce_tag = all_one;
         default:   reduce_tag = legacy ? any_one : parity;
      endcase
   endfunction

endpackage

// File: rtl/stage2_tag_fifo_if.sv
// Valid/ready bundle between stage 1, the stage-2 tag FIFO and stage 3.
interface stage2_tag_fifo_if #(
   parameter int DATA_W = 16,
   parameter int TAG_W  = 1,
   parameter int KEY_W  = 5,
   parameter int DEPTH  = 4
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [KEY_W-1:0]        key_bits;
   logic [DATA_W-1:0]       in_data;
   logic                    in_valid;
   logic                    in_ready;
   logic [DATA_W+TAG_W-1:0] out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [CNT_W-1:0]        count;
   logic                    done;

   modport master (
      output key_bits, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, count, done
   );

   modport slave (
      input  key_bits, in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, count, done
   );
endinterface

// File: rtl/stage2_tag_fifo_sync.sv
// Single-clock FIFO with occupancy count; read data is zero while empty so the
// consumer never sees stale entries.
module stage_sync_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 4
) (
   input  logic                         clk2,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             wr_data,
   output logic [WIDTH-1:0]             rd_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign count   = count_q;
   assign rd_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk2) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage carries no reset; occupancy alone decides what is visible.
   always_ff @(posedge clk2) begin
      if (!rst && do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/stage2_tag_fifo.sv
// Stage 2 of the cipher pipeline: appends key-selected reduction tags to each
// accepted stage-1 word and queues {data, tags} for stage 3.
module stage2_tag_fifo
   import stage_pkg::*;
#(
   parameter int DATA_W       = 16,
   parameter int TAG_W        = 1,
   parameter int KEY_W        = 5,
   parameter int DEPTH        = 4,
   parameter bit LEGACY_MODE3 = 1'b1
) (
   input logic              clk2,
   input logic              rst,
   stage2_tag_fifo_if.slave bus
);
   localparam int LANE_W = DATA_W / TAG_W;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic [TAG_W-1:0]        tag;
   logic [DATA_W+TAG_W-1:0] rd_data;
   logic [CNT_W-1:0]        count;
   logic                    full;
   logic                    empty;
   logic                    push;
   logic                    pop;
   logic                    done_q;
   logic                    unused_key;

   for (genvar i = 0; i < TAG_W; i++) begin : g_lane
      logic [SLICE_MAX-1:0] slice;
      assign slice  = SLICE_MAX'(bus.in_data[i*LANE_W +: LANE_W]);
      assign tag[i] = reduce_tag(slice, bus.key_bits[2*i +: 2], LEGACY_MODE3, LANE_W);
   end

   // Key bits above the lane modes carry nothing for this stage.
   assign unused_key = ^bus.key_bits;

   assign push = bus.in_valid & ~full;
   assign pop  = bus.out_ready & ~empty;

   stage_sync_fifo #(
      .WIDTH (DATA_W + TAG_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk2    (clk2),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .wr_data ({bus.in_data, tag}),
      .rd_data (rd_data),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   always_ff @(posedge clk2) begin
      if (rst)       done_q <= 1'b0;
      else if (push) done_q <= 1'b1;
   end

   assign bus.in_ready  = ~full;
   assign bus.out_valid = ~empty;
   assign bus.out_data  = rd_data;
   assign bus.count     = count;
   assign bus.done      = done_q;

endmodule
